// File: rtl/ram_arbiter_pkg.sv
// Shared types for the two-master ram_bus arbiter: FSM states, master indices
// and the address-tag encodings carried on addr_tag ({mode[2:1], lock[0]}).
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_M0 = 2'd1,
    GNT_M1 = 2'd2
  } arb_state_t;

  localparam logic MST_M0 = 1'b0;
  localparam logic MST_M1 = 1'b1;

  localparam logic [1:0] ADDR_TAG_MODE_NONE = 2'b00;
  localparam logic [1:0] ADDR_TAG_MODE_LRSC = 2'b01;
  localparam logic [1:0] ADDR_TAG_MODE_AMO  = 2'b10;
  localparam logic       ADDR_TAG_UNLOCK    = 1'b0;
  localparam logic       ADDR_TAG_LOCK      = 1'b1;
  localparam logic [2:0] ADDR_TAG_NONE      = {ADDR_TAG_MODE_NONE, ADDR_TAG_UNLOCK};

endpackage

// File: rtl/ram_arb_timeout.sv
// Ack watchdog: counts cycles a granted strobe waits; expire fires on the TIMEOUT_CYCLES-th waiting cycle.
// Latency: expire is combinational in the expiring cycle; count low (or expiry) reloads the counter.
// Backpressure: none, pure observer of the granted strobe.
module ram_arb_timeout #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1024
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic count,
  output logic expire
);

  logic [31:0] cnt;

  assign expire = count & (cnt == 32'd0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt <= TIMEOUT_CYCLES - 32'd1;
    end else if (!count || expire) begin
      cnt <= TIMEOUT_CYCLES - 32'd1;
    end else begin
      cnt <= cnt - 32'd1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master Wishbone arbiter (fetch M0, data M1) onto ram_bus; grant held for the whole cyc, round-robin on ties.
// Latency: 1-cycle registered arbitration, then zero-latency combinational pass-through per beat.
// Backpressure: losing master waits with ack=0; ARB_TIMEOUT_EN adds an ack watchdog that errors and releases the grant.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  input  logic [31:0] m0_addr_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_data_o,
  output logic        m0_err_o,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_addr_i,
  input  logic [2:0]  m1_addr_tag_i,
  input  logic [31:0] m1_data_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_data_o,
  output logic        m1_data_tag_o,
  output logic        m1_err_o,
  output logic        ram_stb_o,
  output logic        ram_cyc_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_addr_o,
  output logic [2:0]  ram_addr_tag_o,
  output logic [31:0] ram_data_o,
  input  logic        ram_ack_i,
  input  logic [31:0] ram_data_i,
  input  logic        ram_data_tag_i
);

  arb_state_t state;
  logic       last_grant;
  logic       m0_req, m1_req;
  logic       gnt0, gnt1;
  logic       expire;

  assign m0_req = m0_cyc_i & m0_stb_i;
  assign m1_req = m1_cyc_i & m1_stb_i;
  assign gnt0   = (state == GNT_M0);
  assign gnt1   = (state == GNT_M1);

`ifdef ARB_TIMEOUT_EN
  logic waiting;

  // Only a granted strobe still waiting on ack ages the watchdog.
  assign waiting = ((gnt0 & m0_req) | (gnt1 & m1_req)) & ~ram_ack_i;

  ram_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .count  (waiting),
    .expire (expire)
  );

  assign m0_err_o = expire & gnt0;
  assign m1_err_o = expire & gnt1;
`else
  assign expire   = 1'b0;
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif

  // Grant is only released when the owner drops cyc, so locked AMO sequences stay atomic.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      last_grant <= MST_M0;
    end else begin
      case (state)
        IDLE: begin
          if (m1_req && (!m0_req || last_grant == MST_M0)) begin
            state      <= GNT_M1;
            last_grant <= MST_M1;
          end else if (m0_req) begin
            state      <= GNT_M0;
            last_grant <= MST_M0;
          end
        end
        GNT_M0: begin
          if (!m0_cyc_i || expire) begin
            if (m1_req) begin
              state      <= GNT_M1;
              last_grant <= MST_M1;
            end else begin
              state <= IDLE;
            end
          end
        end
        GNT_M1: begin
          if (!m1_cyc_i || expire) begin
            if (m0_req) begin
              state      <= GNT_M0;
              last_grant <= MST_M0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ram_stb_o      = ((gnt0 & m0_stb_i) | (gnt1 & m1_stb_i)) & ~expire;
  assign ram_cyc_o      = ((gnt0 & m0_cyc_i) | (gnt1 & m1_cyc_i)) & ~expire;
  assign ram_we_o       = gnt1 & m1_we_i;
  assign ram_sel_o      = gnt1 ? m1_sel_i      : (gnt0 ? 4'hF      : 4'h0);
  assign ram_addr_o     = gnt1 ? m1_addr_i     : (gnt0 ? m0_addr_i : 32'h0);
  assign ram_addr_tag_o = gnt1 ? m1_addr_tag_i : ADDR_TAG_NONE;
  assign ram_data_o     = gnt1 ? m1_data_i     : 32'h0;

  assign m0_ack_o      = ram_ack_i & gnt0;
  assign m1_ack_o      = ram_ack_i & gnt1;
  assign m1_data_tag_o = ram_data_tag_i & gnt1;
  // Read data is shared by both masters; held at zero while the bus is idle or in reset.
  assign m0_data_o     = (state != IDLE) ? ram_data_i : 32'h0;
  assign m1_data_o     = (state != IDLE) ? ram_data_i : 32'h0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: vector table for single transfers and handoffs, hand sequences for
// round-robin, AMO lock hold, SC tag gating, ack timeout/stall and mid-grant reset.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        m0_stb_i, m0_cyc_i;
  logic [31:0] m0_addr_i;
  logic        m0_ack_o, m0_err_o;
  logic [31:0] m0_data_o;
  logic        m1_stb_i, m1_cyc_i, m1_we_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_addr_i;
  logic [2:0]  m1_addr_tag_i;
  logic [31:0] m1_data_i;
  logic        m1_ack_o, m1_data_tag_o, m1_err_o;
  logic [31:0] m1_data_o;
  logic        ram_stb_o, ram_cyc_o, ram_we_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_addr_o;
  logic [2:0]  ram_addr_tag_o;
  logic [31:0] ram_data_o;
  logic        ram_ack_i;
  logic [31:0] ram_data_i;
  logic        ram_data_tag_i;

  always #5 clk_i = ~clk_i;

  ram_arbiter #(.TIMEOUT_CYCLES(32'd16)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_addr_i(m0_addr_i),
    .m0_ack_o(m0_ack_o), .m0_data_o(m0_data_o), .m0_err_o(m0_err_o),
    .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_addr_i(m1_addr_i), .m1_addr_tag_i(m1_addr_tag_i), .m1_data_i(m1_data_i),
    .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o), .m1_data_tag_o(m1_data_tag_o), .m1_err_o(m1_err_o),
    .ram_stb_o(ram_stb_o), .ram_cyc_o(ram_cyc_o), .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o),
    .ram_addr_o(ram_addr_o), .ram_addr_tag_o(ram_addr_tag_o), .ram_data_o(ram_data_o),
    .ram_ack_i(ram_ack_i), .ram_data_i(ram_data_i), .ram_data_tag_i(ram_data_tag_i)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        m0_req;
    logic        m1_req;
    logic        ack;
    logic        e_stb;
    logic        e_cyc;
    logic [31:0] e_addr;
    logic        e_we;
    logic [3:0]  e_sel;
    logic        e_m0ack;
    logic        e_m1ack;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic r0, input logic r1, input logic ack);
    m0_cyc_i  = r0;
    m0_stb_i  = r0;
    m1_cyc_i  = r1;
    m1_stb_i  = r1;
    ram_ack_i = ack;
  endtask

  initial begin
    logic exp_m1;
    rst_n_i = 1'b0;
    m0_addr_i = 32'h0000_1000;
    m1_addr_i = 32'h0000_2000;
    m1_sel_i = 4'h3;
    m1_we_i = 1'b1;
    m1_addr_tag_i = ADDR_TAG_NONE;
    m1_data_i = 32'h0;
    ram_data_i = 32'h0;
    ram_data_tag_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_stb", {31'b0, ram_stb_o}, 32'd0);
    chk("rst_cyc", {31'b0, ram_cyc_o}, 32'd0);
    chk("rst_addr", ram_addr_o, 32'd0);
    chk("rst_acks", {30'b0, m0_ack_o, m1_ack_o}, 32'd0);
    tick();
    tick();
    rst_n_i = 1'b1;

    //            m0    m1    ack   stb   cyc   addr          we    sel   m0ack m1ack
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 4'h0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_1000, 1'b0, 4'hF, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_1000, 1'b0, 4'hF, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1000, 1'b0, 4'hF, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 4'h0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 4'h0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_2000, 1'b1, 4'h3, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_2000, 1'b1, 4'h3, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_1000, 1'b0, 4'hF, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1000, 1'b0, 4'hF, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_2000, 1'b1, 4'h3, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_2000, 1'b1, 4'h3, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 4'h0, 1'b0, 1'b0};

    ram_data_i = 32'hDEAD_BEEF;
    for (int i = 0; i < 13; i++) begin
      tick();
      drive(vecs[i].m0_req, vecs[i].m1_req, vecs[i].ack);
      #1;
      chk($sformatf("v%0d_stb", i), {31'b0, ram_stb_o}, {31'b0, vecs[i].e_stb});
      chk($sformatf("v%0d_cyc", i), {31'b0, ram_cyc_o}, {31'b0, vecs[i].e_cyc});
      chk($sformatf("v%0d_addr", i), ram_addr_o, vecs[i].e_addr);
      chk($sformatf("v%0d_we", i), {31'b0, ram_we_o}, {31'b0, vecs[i].e_we});
      chk($sformatf("v%0d_sel", i), {28'b0, ram_sel_o}, {28'b0, vecs[i].e_sel});
      chk($sformatf("v%0d_m0ack", i), {31'b0, m0_ack_o}, {31'b0, vecs[i].e_m0ack});
      chk($sformatf("v%0d_m1ack", i), {31'b0, m1_ack_o}, {31'b0, vecs[i].e_m1ack});
      if (vecs[i].e_m0ack) chk($sformatf("v%0d_m0data", i), m0_data_o, 32'hDEAD_BEEF);
      if (vecs[i].e_m1ack) chk($sformatf("v%0d_m1data", i), m1_data_o, 32'hDEAD_BEEF);
    end

    // Round-robin: last grant was M1, so contention starts with M0 and alternates.
    tick();
    drive(1'b1, 1'b1, 1'b0);
    #1;
    chk("rr_idle_stb", {31'b0, ram_stb_o}, 32'd0);
    exp_m1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      drive(1'b1, 1'b1, 1'b1);
      #1;
      chk($sformatf("rr%0d_addr", k), ram_addr_o, exp_m1 ? 32'h0000_2000 : 32'h0000_1000);
      chk($sformatf("rr%0d_m1ack", k), {31'b0, m1_ack_o}, {31'b0, exp_m1});
      chk($sformatf("rr%0d_m0ack", k), {31'b0, m0_ack_o}, {31'b0, ~exp_m1});
      tick();
      if (exp_m1) drive(1'b1, 1'b0, 1'b0);
      else        drive(1'b0, 1'b1, 1'b0);
      exp_m1 = ~exp_m1;
    end
    tick();
    drive(1'b0, 1'b0, 1'b0);
    tick();
    chk("rr_end_idle", ram_addr_o, 32'd0);

    // AMO lock/unlock: M1 keeps cyc through a strobe gap; M0 must wait.
    m1_we_i = 1'b0;
    m1_addr_tag_i = {ADDR_TAG_MODE_AMO, ADDR_TAG_LOCK};
    drive(1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b1);
    ram_data_i = 32'h0000_00AA;
    #1;
    chk("amo_lock_tag", {29'b0, ram_addr_tag_o}, {29'b0, ADDR_TAG_MODE_AMO, ADDR_TAG_LOCK});
    chk("amo_lock_ack", {31'b0, m1_ack_o}, 32'd1);
    chk("amo_lock_data", m1_data_o, 32'h0000_00AA);
    for (int g = 0; g < 2; g++) begin
      tick();
      drive(1'b1, 1'b0, 1'b0);
      m1_cyc_i = 1'b1;
      #1;
      chk($sformatf("amo_gap%0d_cyc", g), {31'b0, ram_cyc_o}, 32'd1);
      chk($sformatf("amo_gap%0d_stb", g), {31'b0, ram_stb_o}, 32'd0);
      chk($sformatf("amo_gap%0d_addr", g), ram_addr_o, 32'h0000_2000);
    end
    tick();
    drive(1'b1, 1'b1, 1'b1);
    m1_we_i = 1'b1;
    m1_addr_tag_i = {ADDR_TAG_MODE_AMO, ADDR_TAG_UNLOCK};
    m1_data_i = 32'h0000_1234;
    #1;
    chk("amo_unl_we", {31'b0, ram_we_o}, 32'd1);
    chk("amo_unl_wdata", ram_data_o, 32'h0000_1234);
    chk("amo_unl_tag", {29'b0, ram_addr_tag_o}, {29'b0, ADDR_TAG_MODE_AMO, ADDR_TAG_UNLOCK});
    chk("amo_unl_m1ack", {31'b0, m1_ack_o}, 32'd1);
    chk("amo_unl_m0ack", {31'b0, m0_ack_o}, 32'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0);
    #1;
    chk("amo_rel_cyc", {31'b0, ram_cyc_o}, 32'd0);
    tick();
    chk("amo_m0_addr", ram_addr_o, 32'h0000_1000);
    chk("amo_m0_stb", {31'b0, ram_stb_o}, 32'd1);
    chk("amo_m0_tag", {29'b0, ram_addr_tag_o}, {29'b0, ADDR_TAG_NONE});
    chk("amo_m0_we", {31'b0, ram_we_o}, 32'd0);
    drive(1'b0, 1'b0, 1'b0);
    tick();

    // SC failure tag only reaches M1 while M1 owns the bus.
    m1_addr_tag_i = {ADDR_TAG_MODE_LRSC, ADDR_TAG_UNLOCK};
    drive(1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b1);
    ram_data_tag_i = 1'b1;
    #1;
    chk("sc_tag_m1", {31'b0, m1_data_tag_o}, 32'd1);
    chk("sc_ack_m1", {31'b0, m1_ack_o}, 32'd1);
    tick();
    drive(1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b1);
    #1;
    chk("sc_tag_m0gnt", {31'b0, m1_data_tag_o}, 32'd0);
    chk("sc_ack_m0", {31'b0, m0_ack_o}, 32'd1);
    chk("sc_ack_m1_off", {31'b0, m1_ack_o}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    ram_data_tag_i = 1'b0;
    tick();

    // Slave never acks an M1 strobe.
    m1_we_i = 1'b0;
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      tick();
`ifdef ARB_TIMEOUT_EN
      chk($sformatf("to%0d_err", i), {31'b0, m1_err_o}, {31'b0, (i == 16)});
      chk($sformatf("to%0d_stb", i), {31'b0, ram_stb_o}, {31'b0, (i != 16 && i != 17)});
`else
      chk($sformatf("to%0d_err", i), {31'b0, m1_err_o}, 32'd0);
      chk($sformatf("to%0d_stb", i), {31'b0, ram_stb_o}, 32'd1);
`endif
      chk($sformatf("to%0d_m0err", i), {31'b0, m0_err_o}, 32'd0);
    end

    // Reset while M1 is granted, then M1 is regranted one cycle after release.
    ram_ack_i = 1'b1;
    ram_data_i = 32'h55AA_55AA;
    ram_data_tag_i = 1'b1;
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("mrst_stb", {31'b0, ram_stb_o}, 32'd0);
    chk("mrst_cyc", {31'b0, ram_cyc_o}, 32'd0);
    chk("mrst_addr", ram_addr_o, 32'd0);
    chk("mrst_m1ack", {31'b0, m1_ack_o}, 32'd0);
    chk("mrst_m1data", m1_data_o, 32'd0);
    chk("mrst_m1tag", {31'b0, m1_data_tag_o}, 32'd0);
    ram_ack_i = 1'b0;
    ram_data_tag_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    #1;
    chk("mrst_rel_idle", {31'b0, ram_stb_o}, 32'd0);
    tick();
    chk("mrst_regrant_stb", {31'b0, ram_stb_o}, 32'd1);
    chk("mrst_regrant_addr", ram_addr_o, 32'h0000_2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
